mc_control_fsm: RTL and testbench

//  Multicycle MIPS control unit: Moore FSM that sequences the shared datapath (PC, IR, regfile, ALU,

---
 rtl/mc_control_fsm.sv | 198 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit.
// Moore FSM sequencing the shared datapath through fetch, decode, execute,
// memory and writeback steps. Outputs are decoded combinationally from the
// current state, with zero and mem_ready as the only extra terms. op and funct
// are also used, but they come from the instruction register and are stable
// for the whole instruction.
// Ports:
//   clk, reset (async, active-low)
//   op, funct  - opcode / function fields from the instruction register
//   zero       - ALU zero flag; mem_ready - memory handshake
//   memwrite, iord, irwrite, pcen, regwrite, memtoreg, regdst, alusrca,
//   alusrcb[1:0], pcsrc[1:0], alucontrol[2:0] - datapath controls
//   illegal_op - pulse in DECODE for an unsupported op
//   state[3:0] - current state (debug)
`timescale 1ns/1ps
module mc_control_fsm #(
    parameter bit EN_BNE      = 1'b1,
    parameter bit EN_MEMREADY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALU_W   = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_e;

    state_e state_q, state_d;
    logic   mem_rdy;

    // Without the handshake, memory always completes in one cycle.
    assign mem_rdy = mem_ready | ~EN_MEMREADY;
    assign state   = STATE_W'(state_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; everything stays 0 while reset is low
    always_comb begin
        state_d    = S_FETCH;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        illegal_op = 1'b0;

        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    alusrcb    = 2'b01;
                    alucontrol = ALU_ADD;
                    irwrite    = mem_rdy;
                    pcen       = mem_rdy;
                    state_d    = mem_rdy ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    // Precompute the branch target into ALUOut
                    alusrcb    = 2'b11;
                    alucontrol = ALU_ADD;
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_RTYPEEX;
                        OP_BEQ:       state_d = S_BEQEX;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JEX;
                        OP_BNE: begin
                            if (EN_BNE) begin
                                state_d = S_BNEEX;
                            end else begin
                                illegal_op = 1'b1;
                            end
                        end
                        default:      illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = ALU_ADD;
                    if (op == OP_LW) begin
                        state_d = S_MEMRD;
                    end else if (op == OP_SW) begin
                        state_d = S_MEMWR;
                    end
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    state_d = mem_rdy ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    state_d  = mem_rdy ? S_FETCH : S_MEMWR;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    case (funct)
                        6'b100010: alucontrol = ALU_SUB;
                        6'b100100: alucontrol = ALU_AND;
                        6'b100101: alucontrol = ALU_OR;
                        6'b101010: alucontrol = ALU_SLT;
                        default:   alucontrol = ALU_ADD;
                    endcase
                    state_d = S_RTYPEWB;
                end
                S_RTYPEWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BEQEX, S_BNEEX: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    pcen       = (state_q == S_BEQEX) ? zero : ~zero;
                end
                S_ADDIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = ALU_ADD;
                    state_d    = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                end
                S_JEX: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized self-checking bench for mc_control_fsm.
// A per-instruction reference model (state path + per-step control table)
// predicts state and every control output each cycle.
`timescale 1ns/1ps
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       memwrite, iord, irwrite, pcen, regwrite, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;
    int path[$];

    always #5 clk = ~clk;

    mc_control_fsm #(.EN_BNE(1'b1), .EN_MEMREADY(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal_op(illegal_op), .state(state)
    );

    logic [15:0] dut_vec;
    assign dut_vec = {memwrite, iord, irwrite, pcen, regwrite, memtoreg, regdst,
                      alusrca, alusrcb, pcsrc, alucontrol, illegal_op};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Step sequence of each instruction class, FETCH first.
    task automatic fill_path(input logic [5:0] o);
        path = {0, 1};
        case (o)
            6'b100011: path = {0, 1, 2, 3, 4};
            6'b101011: path = {0, 1, 2, 5};
            6'b000000: path = {0, 1, 6, 7};
            6'b000100: path = {0, 1, 8};
            6'b000101: path = {0, 1, 12};
            6'b001000: path = {0, 1, 9, 10};
            6'b000010: path = {0, 1, 11};
            default:   path = {0, 1};
        endcase
    endtask

    function automatic logic is_legal(input logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                         6'b000101, 6'b001000, 6'b000010};
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Control table: what each step must drive.
    function automatic logic [15:0] exp_out(input int st, input logic [5:0] o,
                                            input logic [5:0] f, input logic z,
                                            input logic mr);
        logic mw, io, irw, pe, rw, m2r, rd, asa, ill;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        {mw, io, irw, pe, rw, m2r, rd, asa, ill} = '0;
        asb = 2'b00; pcs = 2'b00; alu = 3'b000;
        case (st)
            0:  begin asb = 2'b01; alu = 3'b010; irw = mr; pe = mr; end
            1:  begin asb = 2'b11; alu = 3'b010; ill = ~is_legal(o); end
            2:  begin asa = 1'b1; asb = 2'b10; alu = 3'b010; end
            3:  io = 1'b1;
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin asa = 1'b1; alu = rtype_alu(f); end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin asa = 1'b1; alu = 3'b110; pcs = 2'b01; pe = z; end
            12: begin asa = 1'b1; alu = 3'b110; pcs = 2'b01; pe = ~z; end
            9:  begin asa = 1'b1; asb = 2'b10; alu = 3'b010; end
            10: rw = 1'b1;
            11: begin pcs = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        return {mw, io, irw, pe, rw, m2r, rd, asa, asb, pcs, alu, ill};
    endfunction

    // mode 0: mem_ready always 1; 1: random; 2: low for first 3 cycles of MEMWR
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int mode,
                             input int abort_at, output int cycles, output int mw_cycles);
        int k, cyc_in, st;
        logic mr;
        fill_path(o);
        k = 0; cyc_in = 0; cycles = 0; mw_cycles = 0;
        while (k < path.size() && cycles < 60) begin
            @(negedge clk);
            st = path[k];
            op = o; funct = f;
            if (k == abort_at) begin
                reset = 1'b0; mem_ready = 1'b1;
                #1;
                check_val("abort_state", 32'(state), 32'd0);
                check_val("abort_outs", 32'(dut_vec), 32'd0);
                @(negedge clk);
                #1;
                check_val("abort_hold_outs", 32'(dut_vec), 32'd0);
                reset = 1'b1; mem_ready = 1'b0;
                return;
            end
            case (mode)
                0:       mr = 1'b1;
                1:       mr = ($urandom_range(0, 9) < 7);
                default: mr = !(st == 5 && cyc_in < 3);
            endcase
            mem_ready = mr;
            zero = 1'($urandom_range(0, 1));
            #1;
            check_val($sformatf("state op=%b step=%0d", o, k), 32'(state), 32'(st));
            check_val($sformatf("outs op=%b st=%0d", o, st), 32'(dut_vec),
                      32'(exp_out(st, o, f, zero, mr)));
            if (memwrite) mw_cycles++;
            cycles++;
            if (!(st == 0 || st == 3 || st == 5) || mr) begin
                k++; cyc_in = 0;
            end else begin
                cyc_in++;
            end
        end
        if (k < path.size()) check_val("timeout", 32'(k), 32'(path.size()));
    endtask

    initial begin
        int cyc, mwc;
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

        reset = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_val("reset_state", 32'(state), 32'd0);
            check_val("reset_outs", 32'(dut_vec), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("release_state", 32'(state), 32'd0);
        check_val("release_irwrite", 32'(irwrite), 32'd1);
        check_val("release_pcen", 32'(pcen), 32'd1);
        mem_ready = 1'b0;

        run_instr(6'b100011, 6'b0, 0, -1, cyc, mwc);
        check_val("cpi_lw", 32'(cyc), 32'd5);
        run_instr(6'b101011, 6'b0, 2, -1, cyc, mwc);
        check_val("sw_memwrite_cycles", 32'(mwc), 32'd4);
        run_instr(6'b101011, 6'b0, 0, -1, cyc, mwc);
        check_val("cpi_sw", 32'(cyc), 32'd4);
        run_instr(6'b000000, 6'b101010, 0, -1, cyc, mwc);
        check_val("cpi_rtype", 32'(cyc), 32'd4);
        run_instr(6'b001000, 6'b0, 0, -1, cyc, mwc);
        check_val("cpi_addi", 32'(cyc), 32'd4);
        run_instr(6'b000100, 6'b0, 0, -1, cyc, mwc);
        check_val("cpi_beq", 32'(cyc), 32'd3);
        run_instr(6'b000101, 6'b0, 0, -1, cyc, mwc);
        check_val("cpi_bne", 32'(cyc), 32'd3);
        run_instr(6'b000010, 6'b0, 0, -1, cyc, mwc);
        check_val("cpi_j", 32'(cyc), 32'd3);
        run_instr(6'b111111, 6'b0, 0, -1, cyc, mwc);
        check_val("illegal_cycles", 32'(cyc), 32'd2);
        run_instr(6'b100011, 6'b0, 0, 3, cyc, mwc);
        run_instr(6'b000000, 6'b100010, 1, -1, cyc, mwc);

        for (int n = 0; n < 120; n++) begin
            run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 5)],
                      ($urandom_range(0, 3) == 0) ? 0 : 1,
                      ($urandom_range(0, 15) == 0) ? 2 : -1, cyc, mwc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
